// File: rtl/stress_pkg.sv
// Shared types and default constants for the stress-cell ramp sequencer.
package stress_pkg;

  localparam int DEF_NUM_BANKS   = 8;
  localparam int DEF_RAMP_CYCLES = 1024;
  localparam int DEF_CNT_W       = 32;

  // Feedback taps of the checksum LFSR: bits 15, 13, 12 and 10.
  localparam logic [15:0] SIG_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_DONE      = 3'd4
  } stress_state_t;

endpackage

// File: rtl/stress_signature.sv
// 16-bit LFSR checksum: shifts in one data bit per enabled cycle, clear wins over enable.
module stress_signature
  import stress_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] signature
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= {signature[14:0], (^(signature & SIG_TAPS)) ^ data_bit};
    end
  end

endmodule

// File: rtl/stress_sequencer.sv
// Ramps stress banks on one at a time, holds full load, ramps them off again;
// abort drops every bank on the next edge. The FSM state is exported for debug.
module stress_sequencer
  import stress_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [CNT_W-1:0]               hold_cycles,
  input  logic [NUM_BANKS-1:0]           bank_dummy,
  output logic [NUM_BANKS-1:0]           bank_enable,
  output logic [$clog2(NUM_BANKS+1)-1:0] active_count,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic [15:0]                    signature,
  output stress_state_t                  state
);

  localparam int AC_W = $clog2(NUM_BANKS + 1);
  localparam int TW   = $clog2(RAMP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RAMP_CYCLES - 1);

  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_val;
  logic             hold_last;
  logic             accept;

  assign busy   = (state == ST_RAMP_UP) || (state == ST_HOLD) || (state == ST_RAMP_DOWN);
  assign done   = (state == ST_DONE);
  assign accept = (state == ST_IDLE) && start && !abort;

  // Extra bit keeps the +1 from wrapping; a latched value of 0 still ends after one cycle.
  assign hold_last = ({1'b0, hold_cnt} + (CNT_W+1)'(1)) >= {1'b0, hold_val};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bank_enable <= '0;
      timer       <= '0;
      hold_cnt    <= '0;
      hold_val    <= '0;
      aborted     <= 1'b0;
    end else if (busy && abort) begin
      state       <= ST_DONE;
      bank_enable <= '0;
      timer       <= '0;
      hold_cnt    <= '0;
      aborted     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RAMP_UP;
            bank_enable <= NUM_BANKS'(1);
            timer       <= '0;
            hold_cnt    <= '0;
            hold_val    <= hold_cycles;
            aborted     <= 1'b0;
          end
        end
        ST_RAMP_UP: begin
          if (timer == TIMER_LAST) begin
            bank_enable <= {bank_enable[NUM_BANKS-2:0], 1'b1};
            timer       <= '0;
            if (bank_enable[NUM_BANKS-2]) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_last) begin
            state       <= ST_RAMP_DOWN;
            bank_enable <= bank_enable >> 1;
            timer       <= '0;
            hold_cnt    <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RAMP_DOWN: begin
          if (timer == TIMER_LAST) begin
            bank_enable <= bank_enable >> 1;
            timer       <= '0;
            if (!bank_enable[1]) begin
              state <= ST_DONE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          bank_enable <= '0;
        end
      endcase
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      active_count = active_count + AC_W'(bank_enable[i]);
    end
  end

  stress_signature u_signature (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .enable    (busy),
    .data_bit  (^(bank_dummy & bank_enable)),
    .signature (signature)
  );

endmodule

// File: tb/tb_stress_sequencer.sv
// Bench for stress_sequencer (4 banks, 4-cycle ramp): scenario timelines are
// built from closed-form edge times and compared cycle by cycle.
module tb_stress_sequencer;
  import stress_pkg::*;

  localparam int NB = 4;
  localparam int RC = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] hold_cycles;
  logic [NB-1:0] bank_dummy;
  logic [NB-1:0] bank_enable;
  logic [2:0]    active_count;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [15:0]   signature;
  stress_state_t state;

  // Entry layout: {busy, done, aborted, bank_enable[3:0], signature[15:0]}
  logic [22:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  stress_sequencer #(.NUM_BANKS(NB), .RAMP_CYCLES(RC), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .hold_cycles  (hold_cycles),
    .bank_dummy   (bank_dummy),
    .bank_enable  (bank_enable),
    .active_count (active_count),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .signature    (signature),
    .state        (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [3:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ (^d)};
  endfunction

  function automatic logic [3:0] therm(input int n);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Number of enabled banks after edge k (edge 0 = accepted start).
  function automatic int model_ones(input int k, input int h, input int a);
    int up_end;
    int h_end;
    up_end = (NB - 1) * RC;
    h_end  = up_end + ((h < 1) ? 1 : h);
    if (a >= 0 && k >= a) return 0;
    if (k < up_end) return 1 + k / RC;
    if (k < h_end) return NB;
    if (k >= h_end + (NB - 1) * RC) return 0;
    return NB - 1 - (k - h_end) / RC;
  endfunction

  function automatic int model_end(input int h, input int a);
    if (a >= 0) return a;
    return (NB - 1) * RC + ((h < 1) ? 1 : h) + (NB - 1) * RC;
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Called right after a falling edge. h: hold_cycles, a: abort edge (-1 none),
  // p1/p2: extra start pulse edges (-1 none).
  task automatic run_seq(input int h, input int a, input int p1, input int p2,
                         input logic [3:0] dummy, input string name);
    int          end_k;
    logic [15:0] sig;
    logic [3:0]  en;
    logic [3:0]  prev_en;
    logic [22:0] e;
    logic [22:0] got;
    end_k   = model_end(h, a);
    sig     = '0;
    prev_en = '0;
    for (int k = 0; k <= end_k + 1; k++) begin
      if (k >= 1 && k <= end_k) sig = lfsr_step(sig, prev_en & dummy);
      en = therm(model_ones(k, h, a));
      e  = {(k < end_k), (k == end_k), (a >= 0 && k >= a), en, sig};
      exp_q.push_back(e);
      prev_en = en;
    end
    hold_cycles = CW'(h);
    bank_dummy  = dummy;
    for (int k = 0; k <= end_k + 1; k++) begin
      start = (k == 0) || (k == p1) || (k == p2);
      abort = (k == a);
      @(posedge clk);
      #1;
      got = {busy, done, aborted, bank_enable, signature};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s edge %0d: busy/done/aborted/en/sig got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                 name, k, got[22], got[21], got[20], got[19:16], got[15:0],
                 e[22], e[21], e[20], e[19:16], e[15:0]);
      end
      checks++;
      if (active_count !== 3'($countones(e[19:16]))) begin
        errors++;
        $display("FAIL %s_active_count edge %0d: got %0d expected %0d",
                 name, k, active_count, $countones(e[19:16]));
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (bank_enable !== 4'b0000) begin errors++; $display("FAIL reset_enable: got %b expected 0000", bank_enable); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)           begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (aborted !== 1'b0)        begin errors++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    checks++; if (signature !== 16'h0000)  begin errors++; $display("FAIL reset_signature: got %h expected 0000", signature); end
    checks++; if (active_count !== 3'd0)   begin errors++; $display("FAIL reset_active_count: got %0d expected 0", active_count); end
    checks++; if (state !== ST_IDLE)       begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_run();
    run_seq(10, -1, -1, -1, 4'b1111, "full_run");
  endtask

  task automatic test_hold_zero();
    // A start during the DONE cycle (sampled at edge 26) must be ignored.
    run_seq(0, -1, 26, -1, 4'($urandom_range(0, 15)), "hold_zero");
  endtask

  task automatic test_abort();
    run_seq(10, 17, -1, -1, 4'b0110, "abort_hold");
    run_seq(3, -1, -1, -1, 4'($urandom_range(0, 15)), "after_abort");
  endtask

  task automatic test_ignored_start();
    run_seq(10, -1, 5, 20, 4'b1111, "ignored_start");
  endtask

  task automatic test_abort_in_idle();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL idle_abort_busy: got %b expected 0", busy); end
    checks++; if (bank_enable !== 4'd0) begin errors++; $display("FAIL idle_abort_enable: got %b expected 0000", bank_enable); end
    checks++; if (state !== ST_IDLE)    begin errors++; $display("FAIL idle_abort_state: got %0d expected %0d", state, ST_IDLE); end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_abort_done: got %b expected 0", done); end
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_zero_dummy();
    run_seq(2, -1, -1, -1, 4'b0000, "zero_dummy");
  endtask

  task automatic test_mid_reset();
    hold_cycles = CW'(10);
    bank_dummy  = 4'b1011;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (bank_enable !== 4'b0111) begin errors++; $display("FAIL mid_reset_pre_enable: got %b expected 0111", bank_enable); end
    @(posedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bank_enable !== 4'b0000) begin errors++; $display("FAIL mid_reset_enable: got %b expected 0000", bank_enable); end
    checks++; if (signature !== 16'h0000)  begin errors++; $display("FAIL mid_reset_signature: got %h expected 0000", signature); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || bank_enable !== 4'b0000) begin
        errors++; $display("FAIL mid_reset_hold cycle %0d: done/en got %b/%b expected 0/0000", c, done, bank_enable);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || state !== ST_IDLE) begin
      errors++; $display("FAIL mid_reset_release: done/state got %b/%0d expected 0/%0d", done, state, ST_IDLE);
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    hold_cycles = '0;
    bank_dummy  = '0;
    test_reset();
    test_full_run();
    test_hold_zero();
    test_abort();
    test_ignored_start();
    test_abort_in_idle();
    test_zero_dummy();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stress_sequencer.md
STRESS_SEQUENCER -- requirements
Module: stress_sequencer

Interface
REQ-001 Parameter NUM_BANKS, default 8: number of pseudorandom stress-cell banks controlled (2..32).
REQ-002 Parameter RAMP_CYCLES, default 1024: clocks between successive bank enable/disable steps (>=1).
REQ-003 Parameter CNT_W, default 32: width of hold counter and hold_cycles.
REQ-004 Clocking: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to run one ramp/hold/ramp sequence.
REQ-008 abort  input  1  request to stop immediately.
REQ-009 hold_cycles  input  CNT_W  full-load duration, sampled only on accepted start.
REQ-010 bank_dummy  input  NUM_BANKS  dummy output of each bank.
REQ-011 bank_enable  output  NUM_BANKS  per-bank enable, registered.
REQ-012 active_count  output  $clog2(NUM_BANKS+1)  number of set bits in bank_enable.
REQ-013 busy  output  1  high in RAMP_UP, HOLD, RAMP_DOWN.
REQ-014 done  output  1  one-cycle pulse in DONE state.
REQ-015 aborted  output  1  valid with done; high if sequence ended by abort.
REQ-016 signature  output  16  running checksum of enabled bank outputs.

Function
REQ-017 States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE; one-hot or binary encoding free.
REQ-018 IDLE: start=1 and abort=0 -> RAMP_UP at that edge; bank_enable<=1 (bank 0), ramp timer<=0, signature<=0, hold value latched.
REQ-019 start while not IDLE is ignored; start with abort in IDLE is ignored.
REQ-020 RAMP_UP: ramp timer counts 0..RAMP_CYCLES-1; on terminal count, next bank enabled LSB-first (bank_enable<={bank_enable,1'b1}), timer<=0.
REQ-021 When the enable step makes all NUM_BANKS set, same edge -> HOLD, hold counter<=0.
REQ-022 HOLD: lasts max(hold_cycles,1) cycles; on final cycle edge -> RAMP_DOWN, highest enabled bank cleared, timer<=0.
REQ-023 RAMP_DOWN: every RAMP_CYCLES cycles clear highest set bit (MSB-first); edge producing bank_enable==0 -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, aborted reflects cause, then IDLE; start in DONE ignored.
REQ-025 abort in RAMP_UP/HOLD/RAMP_DOWN: next edge bank_enable<=0, -> DONE, aborted<=1; abort in IDLE/DONE has no effect.
REQ-026 aborted cleared on accepted start; held otherwise.
REQ-027 signature, while busy: signature<={signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10] ^ (XOR-reduce(bank_dummy & bank_enable))}; frozen when not busy.
REQ-028 active_count is combinational popcount of registered bank_enable, never exceeds NUM_BANKS.
REQ-029 Counters never wrap: ramp timer width $clog2(RAMP_CYCLES+1); hold counter CNT_W, saturating compare against latched value.
REQ-030 bank_enable is always a thermometer code (contiguous ones from bit 0).

Reset
REQ-031 reset asserted: state=IDLE, bank_enable=0, busy=0, done=0, aborted=0, signature=0, all counters 0, asynchronously.
REQ-032 reset mid-sequence drops all enables in the same cycle; no done pulse is produced.
REQ-033 Deassertion is synchronised externally; block requires no extra cycles after deassert.

Structure
REQ-034 Package stress_pkg holds state enum type stress_state_t and default constants for NUM_BANKS, RAMP_CYCLES, signature taps.
REQ-035 One sub-module stress_signature (16-bit LFSR checksum with enable/clear) is instantiated; all else in stress_sequencer.
REQ-036 bank_enable bit i drives the enable of pseudorandom stress bank i; bank_dummy bit i returns its dummy output.

Verification (NUM_BANKS=4, RAMP_CYCLES=4 unless stated)
REQ-037 start at edge 0, hold_cycles=10 -> bank_enable 0001@0, 0011@4, 0111@8, 1111@12 (HOLD), 0111@22, 0011@26, 0001@30, 0000@34, done=1 for cycle after 34, aborted=0.
REQ-038 hold_cycles=0 -> HOLD lasts 1 cycle: 1111@12, 0111@13, 0000@25, then done pulse.
REQ-039 abort at edge 17 (HOLD) -> bank_enable 0000 at edge 17, done=1 and aborted=1 next cycle, IDLE after; second start then runs normally with aborted=0.
REQ-040 start pulses at edges 5 and 20 during a run -> ignored, timeline identical to REQ-037; start with abort in IDLE -> stays IDLE.
REQ-041 reset asserted at edge 9 for 3 cycles -> bank_enable=0, signature=0 immediately, no done pulse.
REQ-042 bank_dummy held 4'b1111 across REQ-037 run -> signature matches reference model of REQ-027; bank_dummy=0 -> signature stays 0.
